dmem_write_buffer: RTL and testbench



---
 rtl/dmem_wbuf_pkg.sv | 20 ++
 rtl/wbuf_entry_array.sv | 90 +++++++++
 rtl/dmem_write_buffer.sv | 173 +++++++++++++++++
 tb/tb_dmem_write_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_wbuf_pkg.sv
// dmem_wbuf_pkg
// Shared state encodings for the data-memory posted-write buffer.
//   up_state_t : upstream (cache-side) request FSM
//   dn_state_t : downstream (memory-side) access FSM
package dmem_wbuf_pkg;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_WFULL = 2'd1,
    U_RMISS = 2'd2,
    U_DONE  = 2'd3
  } up_state_t;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_READ  = 2'd1,
    D_WRITE = 2'd2
  } dn_state_t;

endpackage

// File: rtl/wbuf_entry_array.sv
// wbuf_entry_array
// DEPTH-entry circular store of posted writes (valid, addr, data) with
// head/tail pointers and an occupancy count, plus a combinational lookup
// that returns the youngest valid entry whose address matches.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   enq, enq_addr/enq_data push one entry at the tail
//   deq                    retire the head entry
//   lookup_addr            address to search for
//   hit, hit_data          match flag and data of the youngest match
//   head_addr, head_data   oldest entry (next to drain)
//   count                  number of valid entries
module wbuf_entry_array #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      idx;

  // Retire is applied before push so that a push into the slot being freed
  // in the same cycle (full buffer, head == tail) leaves it valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= enq_addr;
      data_mem[tail] <= enq_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (addr_mem[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
// Posted-write buffer between the data-cache miss/write-back port and the
// memory model's strobe/done port. Writes complete upstream in one cycle and
// drain to memory in FIFO order; reads hit on buffered data (youngest entry)
// or are forwarded to memory ahead of pending drains.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   strobe_i, addr_i, wdata_i, rw_i   upstream request (rw_i=1 write)
//   rdata_o, done_o                   upstream completion and read data
//   empty_o                           nothing buffered, downstream idle
//   strobe_o, addr_o, wdata_o, rw_o   downstream request, held until done_i
//   rdata_i, done_i                   downstream completion and read data
module dmem_write_buffer
  import dmem_wbuf_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rw_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  empty_o,
  output logic                  strobe_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  rw_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  done_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  up_state_t             u_state, u_next;
  dn_state_t             d_state, d_next;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  enq, deq, hit, full, miss_now;
  logic [ADDR_WIDTH-1:0] enq_addr, head_addr;
  logic [DATA_WIDTH-1:0] enq_data, hit_data, head_data;
  logic [CNT_W-1:0]      count;

  wbuf_entry_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .enq        (enq),
    .enq_addr   (enq_addr),
    .enq_data   (enq_data),
    .deq        (deq),
    .lookup_addr(addr_i),
    .hit        (hit),
    .hit_data   (hit_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count)
  );

  assign full     = (count == CNT_W'(DEPTH));
  assign deq      = (d_state == D_WRITE) && done_i;
  assign miss_now = (u_state == U_IDLE) && strobe_i && !rw_i && !hit;

  // Upstream FSM: state register
  always_ff @(posedge clk) begin
    if (rst) u_state <= U_IDLE;
    else     u_state <= u_next;
  end

  // Upstream FSM: next state. A head retiring this cycle frees its slot for
  // the stalled write at the same edge, so it lands in the following cycle.
  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE:
        if (strobe_i) begin
          if (rw_i) u_next = full ? U_WFULL : U_DONE;
          else      u_next = hit ? U_DONE : U_RMISS;
        end
      U_WFULL: if (!full || deq) u_next = U_DONE;
      U_RMISS: if ((d_state == D_READ) && done_i) u_next = U_DONE;
      U_DONE:  u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  // Upstream FSM: outputs
  always_comb begin
    done_o   = (u_state == U_DONE);
    enq      = 1'b0;
    enq_addr = addr_i;
    enq_data = wdata_i;
    case (u_state)
      U_IDLE:  enq = strobe_i && rw_i && !full;
      U_WFULL: begin
        enq      = !full || deq;
        enq_addr = req_addr;
        enq_data = req_data;
      end
      default: enq = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if ((u_state == U_IDLE) && strobe_i) begin
      req_addr <= addr_i;
      req_data <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                                    rdata_o <= '0;
    else if ((u_state == U_IDLE) && strobe_i && !rw_i && hit)   rdata_o <= hit_data;
    else if ((u_state == U_RMISS) && (d_state == D_READ) && done_i) rdata_o <= rdata_i;
    else if (u_state == U_DONE)                                 rdata_o <= '0;
  end

  // Downstream FSM: state register
  always_ff @(posedge clk) begin
    if (rst) d_state <= D_IDLE;
    else     d_state <= d_next;
  end

  // Downstream FSM: next state. A read miss (pending or arriving now) goes
  // ahead of draining; it cannot alias any buffered address. An enqueue into
  // an empty buffer is issued in the same cycle it is written.
  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:
        if ((u_state == U_RMISS) || miss_now) d_next = D_READ;
        else if ((count != '0) || enq)        d_next = D_WRITE;
      D_READ, D_WRITE: if (done_i) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // Downstream FSM: registered outputs, loaded on entry and held until done_i
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_o <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      rw_o     <= 1'b0;
      empty_o  <= 1'b1;
    end else begin
      strobe_o <= (d_state == D_IDLE) && (d_next != D_IDLE);
      empty_o  <= (count == '0) && (d_state == D_IDLE);
      if ((d_state == D_IDLE) && (d_next == D_READ)) begin
        addr_o  <= miss_now ? addr_i : req_addr;
        wdata_o <= '0;
        rw_o    <= 1'b0;
      end else if ((d_state == D_IDLE) && (d_next == D_WRITE)) begin
        addr_o  <= (count != '0) ? head_addr : enq_addr;
        wdata_o <= (count != '0) ? head_data : enq_data;
        rw_o    <= 1'b1;
      end
    end
  end

  // Only one upstream request may be outstanding; extra strobes are dropped.
  a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(strobe_i && (u_state != U_IDLE)))
    else $warning("dmem_write_buffer: strobe_i while busy, request ignored");

endmodule

// File: tb/tb_dmem_write_buffer.sv
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe_i, rw_i, done_o, empty_o, strobe_o, rw_o, done_i;
  logic [31:0] addr_i, wdata_i, rdata_o, addr_o, wdata_o, rdata_i;

  always #5 clk = ~clk;

  dmem_write_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .strobe_i(strobe_i), .addr_i(addr_i), .wdata_i(wdata_i), .rw_i(rw_i),
    .rdata_o(rdata_o), .done_o(done_o), .empty_o(empty_o),
    .strobe_o(strobe_o), .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o),
    .rdata_i(rdata_i), .done_i(done_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepts strobe_o, raises done_i 'lat' cycles later.
  // It deliberately ignores rst so a late done_i can be observed.
  typedef struct { logic rw; logic [31:0] addr; logic [31:0] data; } iss_t;
  logic [31:0] mem [logic [31:0]];
  iss_t        iss_q[$];
  int          done_q[$];
  int          lat = 8;
  int          m_cnt = 0;
  bit          m_busy = 0;

  initial begin
    done_i  = 1'b0;
    rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      done_i = 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          done_i = 1'b1;
          m_busy = 0;
          done_q.push_back(cyc);
          if (rw_o) mem[addr_o] = wdata_o;
          else      rdata_i = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
        end else begin
          m_cnt--;
        end
      end else if (strobe_o) begin
        m_busy = 1;
        m_cnt  = lat;
        iss_q.push_back('{rw_o, addr_o, wdata_o});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Issue one request; returns cycles to done_o, the done cycle and rdata_o.
  // stray_at > 0 pulses an illegal extra write strobe at that cycle offset.
  task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input int stray_at, output int k, output int dcyc,
                        output logic [31:0] rd);
    strobe_i = 1'b1; rw_i = rw; addr_i = a; wdata_i = d;
    k = 0; dcyc = -1; rd = '0;
    while (k < 200) begin
      step();
      k++;
      if (done_o) begin
        rd = rdata_o;
        dcyc = cyc;
        break;
      end
      strobe_i = (k == stray_at);
      if (k == stray_at) begin
        rw_i = 1'b1; addr_i = 32'h600; wdata_i = 32'h99;
      end
    end
    strobe_i = 1'b0;
    step();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!(empty_o && !m_busy) && n < 300) begin
      step();
      n++;
    end
    chk(name, {31'b0, empty_o && !m_busy}, 32'h1);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_k;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin : main
    vec_t        vecs[5];
    int          k, dc, t0, x;
    logic [31:0] rd;
    bit          saw_strobe;

    vecs[0] = '{1'b1, 32'h100, 32'hAAAA5555, 8, 1, 32'h0};
    vecs[1] = '{1'b0, 32'h100, 32'h0,        3, 5, 32'hAAAA5555};
    vecs[2] = '{1'b0, 32'h400, 32'h0,        1, 3, 32'h12345678};
    vecs[3] = '{1'b1, 32'h204, 32'hCAFEF00D, 2, 1, 32'h0};
    vecs[4] = '{1'b0, 32'h204, 32'h0,        5, 7, 32'hCAFEF00D};

    mem[32'h400] = 32'h12345678;
    mem[32'h300] = 32'hDEADBEEF;
    mem[32'h704] = 32'h0BADF00D;

    rst = 1'b1; strobe_i = 1'b0; rw_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) step();
    chk("rst_done_o",   {31'b0, done_o},   32'h0);
    chk("rst_strobe_o", {31'b0, strobe_o}, 32'h0);
    chk("rst_rw_o",     {31'b0, rw_o},     32'h0);
    chk("rst_empty_o",  {31'b0, empty_o},  32'h1);
    chk("rst_addr_o",   addr_o,  32'h0);
    chk("rst_wdata_o",  wdata_o, 32'h0);
    chk("rst_rdata_o",  rdata_o, 32'h0);
    rst = 1'b0;
    step();

    // Table: isolated writes, read misses served by memory
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 0, k, dc, rd);
      chk($sformatf("vec%0d_latency", i), k, vecs[i].exp_k);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      wait_empty($sformatf("vec%0d_empty", i));
    end

    // Single write: downstream issue timing and empty_o after done_i
    lat = 8;
    t0 = cyc;
    strobe_i = 1'b1; rw_i = 1'b1; addr_i = 32'h100; wdata_i = 32'hAAAA5555;
    step();
    strobe_i = 1'b0;
    chk("A_done_o",   {31'b0, done_o},   32'h1);
    chk("A_strobe_o", {31'b0, strobe_o}, 32'h1);
    chk("A_addr_o",   addr_o, 32'h100);
    chk("A_rw_o",     {31'b0, rw_o}, 32'h1);
    chk("A_wdata_o",  wdata_o, 32'hAAAA5555);
    x = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done_i) begin
        x = cyc;
        break;
      end
    end
    chk("A_done_i_cycle", x - t0, 9);
    step();
    chk("A_empty_low", {31'b0, empty_o}, 32'h0);
    step();
    chk("A_empty_high", {31'b0, empty_o}, 32'h1);
    step();

    // Duplicate addresses: read hits youngest, both drained in order
    iss_q.delete();
    lat = 8;
    do_req(1'b1, 32'h200, 32'h1, 0, k, dc, rd);
    do_req(1'b1, 32'h200, 32'h2, 0, k, dc, rd);
    do_req(1'b0, 32'h200, 32'h0, 0, k, dc, rd);
    chk("B_hit_latency", k, 1);
    chk("B_hit_rdata", rd, 32'h2);
    chk("B_rdata_cleared", rdata_o, 32'h0);
    wait_empty("B_empty");
    chk("B_issue_count", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("B_first_rw",   {31'b0, iss_q[0].rw}, 32'h1);
      chk("B_first_data", iss_q[0].data, 32'h1);
      chk("B_second_rw",  {31'b0, iss_q[1].rw}, 32'h1);
      chk("B_second_data", iss_q[1].data, 32'h2);
    end

    // Five back-to-back writes into a 4-deep buffer
    iss_q.delete();
    done_q.delete();
    lat = 8;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 32'h800 + 32'(4 * i), 32'h50 + 32'(i), 0, k, dc, rd);
      if (i < 4) chk($sformatf("C_w%0d_latency", i), k, 1);
      else       chk("C_w4_done_cycle", dc, (done_q.size() > 0) ? done_q[0] + 1 : -1);
    end
    wait_empty("C_empty");
    chk("C_issue_count", iss_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < iss_q.size())
        chk($sformatf("C_issue%0d_addr", i), iss_q[i].addr, 32'h800 + 32'(4 * i));
    end

    // Read miss bypasses buffered writes; stray strobe while waiting is dropped
    iss_q.delete();
    done_q.delete();
    lat = 8;
    do_req(1'b1, 32'h500, 32'h11, 0, k, dc, rd);
    do_req(1'b1, 32'h504, 32'h22, 0, k, dc, rd);
    do_req(1'b1, 32'h508, 32'h33, 0, k, dc, rd);
    do_req(1'b0, 32'h300, 32'h0, 2, k, dc, rd);
    chk("D_miss_rdata", rd, 32'hDEADBEEF);
    chk("D_miss_done_cycle", dc, (done_q.size() > 0) ? done_q[$] + 1 : -1);
    wait_empty("D_empty");
    chk("D_issue_count", iss_q.size(), 4);
    if (iss_q.size() == 4) begin
      chk("D_issue0_addr", iss_q[0].addr, 32'h500);
      chk("D_issue1_addr", iss_q[1].addr, 32'h300);
      chk("D_issue1_rw",   {31'b0, iss_q[1].rw}, 32'h0);
      chk("D_issue2_addr", iss_q[2].addr, 32'h504);
      chk("D_issue3_addr", iss_q[3].addr, 32'h508);
    end

    // Reset mid-drain with three entries buffered
    iss_q.delete();
    lat = 8;
    do_req(1'b1, 32'h700, 32'h70, 0, k, dc, rd);
    do_req(1'b1, 32'h704, 32'h74, 0, k, dc, rd);
    do_req(1'b1, 32'h708, 32'h78, 0, k, dc, rd);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("E_done_o",   {31'b0, done_o},   32'h0);
    chk("E_strobe_o", {31'b0, strobe_o}, 32'h0);
    chk("E_rw_o",     {31'b0, rw_o},     32'h0);
    chk("E_empty_o",  {31'b0, empty_o},  32'h1);
    chk("E_addr_o",   addr_o,  32'h0);
    chk("E_wdata_o",  wdata_o, 32'h0);
    chk("E_rdata_o",  rdata_o, 32'h0);
    saw_strobe = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (strobe_o) saw_strobe = 1;
    end
    chk("E_no_issue_after_rst", {31'b0, saw_strobe}, 32'h0);
    wait_empty("E_empty_after_late_done");
    chk("E_issue_count", iss_q.size(), 1);
    lat = 2;
    do_req(1'b0, 32'h704, 32'h0, 0, k, dc, rd);
    chk("E_dropped_read_latency", k, 4);
    chk("E_dropped_read_rdata", rd, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
